// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - Nios-side Z80 bus takeover arbiter (BUSRQ/BUSAK handshake with guard timing)
module z80_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TURNAROUND     = 4,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_req_n,
    input  logic       busak_n,
    input  logic       clear_err,
    output logic       busrq_n,
    output logic       bus_oe,
    output logic       granted,
    output logic [1:0] err
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_GUARD_IN, S_OWN, S_GUARD_OUT, S_RELEASE, S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t         state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic           sync1, busak_s;
    logic [1:0]     err_nx;
    logic           busrq_n_nx, bus_oe_nx, granted_nx;

    // Outputs are flops fed from the next-state decode, so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            busak_s <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            err     <= 2'b00;
            busrq_n <= 1'b1;
            bus_oe  <= 1'b0;
            granted <= 1'b0;
        end else begin
            sync1   <= busak_n;
            busak_s <= sync1;
            state   <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            err     <= err_nx;
            busrq_n <= busrq_n_nx;
            bus_oe  <= bus_oe_nx;
            granted <= granted_nx;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = err;
        case (state)
            S_IDLE: begin
                if (!bus_req_n)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                if (!busak_s)
                    state_nx = S_GUARD_IN;
                else if (bus_req_n)
                    state_nx = S_RELEASE;
                else if (cnt == TIMEOUT_LAST) begin
                    state_nx  = S_ERR;
                    err_nx[0] = 1'b1;
                end
            end
            S_GUARD_IN: begin
                if (bus_req_n)
                    state_nx = S_GUARD_OUT;
                else if (cnt == GUARD_LAST)
                    state_nx = S_OWN;
            end
            S_OWN: begin
                // Losing BUSAK outranks a normal release request.
                if (busak_s) begin
                    state_nx  = S_ERR;
                    err_nx[1] = 1'b1;
                end else if (bus_req_n)
                    state_nx = S_GUARD_OUT;
            end
            S_GUARD_OUT: begin
                if (cnt == GUARD_LAST)
                    state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                if (busak_s)
                    state_nx = S_IDLE;
            end
            S_ERR: begin
                if (clear_err && bus_req_n) begin
                    state_nx = S_IDLE;
                    err_nx   = 2'b00;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busrq_n_nx = 1'b0;
        bus_oe_nx  = 1'b0;
        granted_nx = 1'b0;
        case (state_nx)
            S_IDLE, S_RELEASE, S_ERR: busrq_n_nx = 1'b1;
            S_OWN: begin
                bus_oe_nx  = 1'b1;
                granted_nx = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - self-checking bench for z80_bus_arbiter
module tb_z80_bus_arbiter;

    localparam int TO = 16;
    localparam int TA = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bus_req_n = 1'b1;
    logic       busak_n = 1'b1;
    logic       clear_err = 1'b0;
    logic       busrq_n, bus_oe, granted;
    logic [1:0] err;

    int checks = 0;
    int errors = 0;

    z80_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TURNAROUND(TA), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus_req_n(bus_req_n), .busak_n(busak_n),
        .clear_err(clear_err), .busrq_n(busrq_n), .bus_oe(bus_oe),
        .granted(granted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit e_rq, input bit e_oe, input bit e_gr, input bit [1:0] e_err);
        check({tag, ".busrq_n"}, {3'b0, busrq_n}, {3'b0, e_rq});
        check({tag, ".bus_oe"},  {3'b0, bus_oe},  {3'b0, e_oe});
        check({tag, ".granted"}, {3'b0, granted}, {3'b0, e_gr});
        check({tag, ".err"},     {2'b0, err},     {2'b0, e_err});
    endtask

    // Reference model: named phases with a dwell count and a two-deep delay line for BUSAK.
    typedef enum int {M_IDLE, M_REQ, M_GIN, M_OWN, M_GOUT, M_REL, M_ERR} phase_t;
    phase_t ph;
    int     dwell;
    bit [1:0] merr;
    bit     ak_line[$];

    task automatic model_reset();
        ph = M_IDLE; dwell = 0; merr = 2'b00; ak_line = '{1'b1, 1'b1};
    endtask

    task automatic model_step(input bit rq, input bit ak, input bit clr);
        bit     seen = ak_line[1];
        phase_t nx = ph;
        ak_line = '{ak, ak_line[0]};
        case (ph)
            M_IDLE: if (!rq) nx = M_REQ;
            M_REQ:  if (!seen) nx = M_GIN;
                    else if (rq) nx = M_REL;
                    else if (dwell + 1 >= TO) begin nx = M_ERR; merr[0] = 1'b1; end
            M_GIN:  if (rq) nx = M_GOUT; else if (dwell + 1 >= TA) nx = M_OWN;
            M_OWN:  if (seen) begin nx = M_ERR; merr[1] = 1'b1; end else if (rq) nx = M_GOUT;
            M_GOUT: if (dwell + 1 >= TA) nx = M_REL;
            M_REL:  if (seen) nx = M_IDLE;
            M_ERR:  if (clr && rq) begin nx = M_IDLE; merr = 2'b00; end
            default: nx = M_IDLE;
        endcase
        dwell = (nx == ph) ? dwell + 1 : 0;
        ph = nx;
    endtask

    typedef struct {
        bit rq; bit ak; bit clr; int n;
        bit e_rq; bit e_oe; bit e_gr; bit [1:0] e_err;
    } vec_t;
    vec_t vt[$];

    bit z80_dead;

    initial begin
        // rq ak clr cycles | busrq_n bus_oe granted err
        vt.push_back('{1,1,0,2, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,1,0,2, 0,0,0,2'b00});
        vt.push_back('{0,0,0,1, 0,0,0,2'b00});
        vt.push_back('{0,0,0,5, 0,0,0,2'b00});
        vt.push_back('{0,0,0,1, 0,1,1,2'b00});
        vt.push_back('{0,0,0,3, 0,1,1,2'b00});
        vt.push_back('{1,0,0,1, 0,0,0,2'b00});
        vt.push_back('{1,0,0,3, 0,0,0,2'b00});
        vt.push_back('{1,0,0,1, 1,0,0,2'b00});
        vt.push_back('{1,1,0,2, 1,0,0,2'b00});
        vt.push_back('{1,1,0,1, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,1,0,14,0,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,1,0,1, 1,0,0,2'b01});
        vt.push_back('{0,1,1,1, 1,0,0,2'b01});
        vt.push_back('{1,1,0,2, 1,0,0,2'b01});
        vt.push_back('{1,1,1,1, 1,0,0,2'b00});
        vt.push_back('{1,1,1,1, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,0,0,7, 0,1,1,2'b00});
        vt.push_back('{0,1,0,2, 0,1,1,2'b00});
        vt.push_back('{0,1,0,1, 1,0,0,2'b10});
        vt.push_back('{1,1,1,1, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,0,0,7, 0,1,1,2'b00});
        vt.push_back('{0,1,0,2, 0,1,1,2'b00});
        vt.push_back('{1,1,0,1, 1,0,0,2'b10});
        vt.push_back('{1,1,1,1, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});
        vt.push_back('{0,0,0,4, 0,0,0,2'b00});
        vt.push_back('{1,0,0,1, 0,0,0,2'b00});
        vt.push_back('{1,0,0,3, 0,0,0,2'b00});
        vt.push_back('{1,0,0,1, 1,0,0,2'b00});
        vt.push_back('{1,1,0,3, 1,0,0,2'b00});
        vt.push_back('{0,1,0,1, 0,0,0,2'b00});

        repeat (2) @(posedge clk);
        #1 check_outs("reset", 1, 0, 0, 2'b00);
        @(negedge clk) reset = 1'b0;

        foreach (vt[i]) begin
            bus_req_n = vt[i].rq; busak_n = vt[i].ak; clear_err = vt[i].clr;
            repeat (vt[i].n) @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vt[i].e_rq, vt[i].e_oe, vt[i].e_gr, vt[i].e_err);
        end

        // Asynchronous reset while owning the bus.
        @(negedge clk) reset = 1'b1; clear_err = 1'b0;
        @(negedge clk) reset = 1'b0; bus_req_n = 1'b0; busak_n = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_outs("own_before_rst", 0, 1, 1, 2'b00);
        #2 reset = 1'b1;
        #1 check_outs("async_rst", 1, 0, 0, 2'b00);
        @(negedge clk) reset = 1'b0; bus_req_n = 1'b1; busak_n = 1'b1;
        @(posedge clk) #1 check_outs("after_rst", 1, 0, 0, 2'b00);
        @(negedge clk) bus_req_n = 1'b0;
        @(posedge clk) #1 check_outs("after_rst_req", 0, 0, 0, 2'b00);

        // Randomized run against the reference model.
        @(negedge clk) reset = 1'b1; bus_req_n = 1'b1; busak_n = 1'b1; clear_err = 1'b0;
        @(negedge clk) reset = 1'b0;
        model_reset();
        z80_dead = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) bus_req_n = ~bus_req_n;
            clear_err = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 2) z80_dead = ~z80_dead;
            if (z80_dead) busak_n = 1'b1;
            else if ($urandom_range(0, 99) < 30) busak_n = busrq_n;
            else if ($urandom_range(0, 99) < 2) busak_n = ~busak_n;
            @(posedge clk);
            model_step(bus_req_n, busak_n, clear_err);
            @(negedge clk);
            check_outs("rand", (ph == M_IDLE || ph == M_REL || ph == M_ERR), ph == M_OWN, ph == M_OWN, merr);
            check("rand.oe_with_release", {3'b0, bus_oe & busrq_n}, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
